// File: rtl/apb_gpio_out_slave.sv
// -----------------------------------------------------------------------------
// apb_gpio_out_slave
//   APB3 slave driving a bank of GPIO outputs. It provides a direct OUT register,
//   write-only SET/CLR/TGL views of it, a one-shot PULSE register whose bits stay
//   high for PULSE_CYCLES cycles, a STAT register, programmable wait states and
//   PSLVERR on undecoded addresses.
//
// Ports
//   PCLK        in   APB clock (single clock domain)
//   PRESET      in   synchronous active-high reset
//   PSEL        in   slave select
//   PADDR       in   byte address; registers at PADDR[4:2], upper bits must be 0
//   PENABLE     in   APB access phase
//   PWRITE      in   1 = write, 0 = read
//   PWDATA      in   write data (bits above GPIO_WIDTH ignored)
//   PRDATA      out  read data (0 outside a completing read)
//   PREADY      out  transfer complete
//   PSLVERR     out  error response, only asserted together with PREADY
//   GPIO_OUT    out  out_reg | pulse_mask
//   PULSE_BUSY  out  high while any pulse bit is active
// -----------------------------------------------------------------------------
module apb_gpio_out_slave #(
    parameter int GPIO_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int WAIT_STATES  = 0,
    parameter int PULSE_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [31:0]           PWDATA,
    output logic [31:0]           PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [GPIO_WIDTH-1:0] GPIO_OUT,
    output logic                  PULSE_BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int                CNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [3:0]        WS_C     = 4'(WAIT_STATES);
    localparam logic              WS_EN_C  = (WAIT_STATES != 0);
    localparam logic [CNT_W-1:0]  RELOAD_C = CNT_W'(PULSE_CYCLES - 1);

    localparam logic [2:0] REG_OUT   = 3'd0;
    localparam logic [2:0] REG_SET   = 3'd1;
    localparam logic [2:0] REG_CLR   = 3'd2;
    localparam logic [2:0] REG_TGL   = 3'd3;
    localparam logic [2:0] REG_PULSE = 3'd4;
    localparam logic [2:0] REG_STAT  = 3'd5;

    // Zero-extend a GPIO-wide value onto the 32-bit read bus.
    function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    apb_state_e             state_q;
    apb_state_e             phase_s;
    logic [3:0]             wait_cnt_q;
    logic [GPIO_WIDTH-1:0]  out_q, out_d;
    logic [GPIO_WIDTH-1:0]  pmask_q, pmask_d;
    logic [CNT_W-1:0]       pcnt_q, pcnt_d;

    logic                   ready_s;
    logic                   xfer_s;
    logic                   addr_err_s;
    logic                   wr_ok_s;
    logic                   rd_ok_s;
    logic                   expire_s;
    logic                   pulse_wr_s;
    logic [2:0]             reg_idx_s;
    logic [GPIO_WIDTH-1:0]  wdata_s;
    logic [31:0]            rdata_s;
    logic                   unused_s;

    assign reg_idx_s = PADDR[4:2];
    assign wdata_s   = PWDATA[GPIO_WIDTH-1:0];
    assign unused_s  = ^{PADDR[1:0], PWDATA};

    // Phase of the current bus cycle. state_q remembers whether a setup phase
    // preceded this cycle, so PENABLE without a prior setup is ignored.
    always_comb begin
        phase_s = ST_IDLE;
        if (PSEL && !PENABLE) begin
            phase_s = ST_SETUP;
        end else if (PSEL && PENABLE && (state_q != ST_IDLE)) begin
            phase_s = ST_ACCESS;
        end else begin
            phase_s = ST_IDLE;
        end
    end

    assign ready_s    = (phase_s != ST_ACCESS) || (wait_cnt_q == WS_C);
    assign xfer_s     = (phase_s == ST_ACCESS) && ready_s;
    assign wr_ok_s    = xfer_s && PWRITE && !addr_err_s;
    assign rd_ok_s    = xfer_s && !PWRITE && !addr_err_s;
    assign expire_s   = (pmask_q != '0) && (pcnt_q == '0);
    assign pulse_wr_s = wr_ok_s && (reg_idx_s == REG_PULSE) && (wdata_s != '0);

    // Address decode: offsets 0x18/0x1C and any nonzero upper bit are errors.
    always_comb begin
        addr_err_s = 1'b0;
        if (|PADDR[ADDR_WIDTH-1:5]) begin
            addr_err_s = 1'b1;
        end else begin
            case (reg_idx_s)
                REG_OUT, REG_SET, REG_CLR, REG_TGL, REG_PULSE, REG_STAT: addr_err_s = 1'b0;
                default:                                                 addr_err_s = 1'b1;
            endcase
        end
    end

    // Next value of the output register for OUT/SET/CLR/TGL writes.
    always_comb begin
        out_d = out_q;
        if (wr_ok_s) begin
            case (reg_idx_s)
                REG_OUT: out_d = wdata_s;
                REG_SET: out_d = out_q | wdata_s;
                REG_CLR: out_d = out_q & ~wdata_s;
                REG_TGL: out_d = out_q ^ wdata_s;
                default: out_d = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // Pulse mask and timer. A nonzero write merges bits and restarts the timer;
    // in the expiry cycle the old bits are dropped so only the new ones remain.
    always_comb begin
        pmask_d = pmask_q;
        pcnt_d  = pcnt_q;
        if (pulse_wr_s) begin
            pmask_d = (expire_s ? '0 : pmask_q) | wdata_s;
            pcnt_d  = RELOAD_C;
        end else if (pmask_q != '0) begin
            if (pcnt_q == '0) begin
                pmask_d = '0;
            end else begin
                pcnt_d = pcnt_q - 1'b1;
            end
        end else begin
            pmask_d = pmask_q;
        end
    end

    // Read data mux, driven only during a completing, decoded read.
    always_comb begin
        rdata_s = 32'h0;
        if (rd_ok_s) begin
            case (reg_idx_s)
                REG_OUT:   rdata_s = zext(out_q);
                REG_PULSE: rdata_s = zext(pmask_q);
                REG_STAT:  rdata_s = {30'h0, (pmask_q != '0), WS_EN_C};
                default:   rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    // Bus tracking state, wait counter and GPIO state registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            out_q      <= '0;
            pmask_q    <= '0;
            pcnt_q     <= '0;
        end else begin
            // A completed access returns to IDLE so a lingering PENABLE is ignored.
            state_q <= xfer_s ? ST_IDLE : phase_s;
            case (phase_s)
                ST_SETUP:  wait_cnt_q <= 4'd0;
                ST_ACCESS: wait_cnt_q <= (wait_cnt_q < WS_C) ? wait_cnt_q + 4'd1 : wait_cnt_q;
                default:   wait_cnt_q <= wait_cnt_q;
            endcase
            out_q   <= out_d;
            pmask_q <= pmask_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign PRDATA     = rdata_s;
    assign PREADY     = ready_s;
    assign PSLVERR    = xfer_s && addr_err_s;
    assign GPIO_OUT   = out_q | pmask_q;
    assign PULSE_BUSY = (pmask_q != '0);

endmodule
